// File: rtl/spi_slave_rx.sv
// Slave-side receiver for the 12-bit LSB-first SPI link: synchronizes sclk/cs/mosi into clk,
// rebuilds each framed word and hands it to a valid/ready consumer with overrun/frame-error pulses.
`timescale 1ns/1ps
module spi_slave_rx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_IN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LEAD_W  = (LEAD_IN > 1) ? $clog2(LEAD_IN) : 1;
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [LEAD_W-1:0]  LEAD_LAST  = LEAD_W'((LEAD_IN > 0) ? (LEAD_IN - 1) : 0);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [FLUSH_W-1:0]     flush_q;
  logic                   armed_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [LEAD_W-1:0]      lead_q;
  logic [DATA_W-1:0]      shreg_q;
  logic                   done_q;
  logic                   frame_err_q;

  logic [DATA_W-1:0]      dout_q;
  logic [DATA_W-1:0]      dout_d;
  logic                   dout_valid_q;
  logic                   dout_valid_d;
  logic                   overrun_q;
  logic                   overrun_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_fall_s;
  logic cs_fall_s;
  logic cs_rise_s;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_fall_s = sclk_prev_q & ~sclk_s;
  // A frame may only start once cs has been seen high after reset.
  assign cs_fall_s   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise_s   = ~cs_prev_q & cs_s;

  // Synchronizers, edge-detect flops and post-reset cs arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (flush_q != FLUSH_DONE) begin
        flush_q <= flush_q + FLUSH_W'(1);
      end else if (cs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Frame FSM: lead-in discard, LSB-first shifting, abort detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      lead_q      <= '0;
      shreg_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) begin
            bitcnt_q <= '0;
            lead_q   <= '0;
            state_q  <= (LEAD_IN == 0) ? ST_SHIFT : ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (cs_rise_s) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (sclk_fall_s) begin
            if (lead_q == LEAD_LAST) begin
              state_q <= ST_SHIFT;
            end else begin
              lead_q <= lead_q + LEAD_W'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (cs_rise_s) begin
            frame_err_q <= 1'b1;
            bitcnt_q    <= '0;
            state_q     <= ST_IDLE;
          end else if (sclk_fall_s) begin
            shreg_q[bitcnt_q] <= mosi_s;
            if (bitcnt_q == BIT_LAST) begin
              bitcnt_q <= '0;
              done_q   <= 1'b1;
              state_q  <= ST_WAIT;
            end else begin
              bitcnt_q <= bitcnt_q + CNT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (cs_rise_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output port: load a finished word, or flag overrun if the last one is still unclaimed.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (done_q) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shreg_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule
